// File: rtl/game_sprite_pkg.sv
// Shared constants and helpers for the sprite engine.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: ERGB width helper, register-port select codes, write-field bit
// positions, reset values and the per-axis motion helper.
package game_sprite_pkg;

   // Register-port select codes; code 3 is reserved and decodes to nothing.
   localparam logic [1:0] SEL_POS = 2'd0;
   localparam logic [1:0] SEL_VEL = 2'd1;
   localparam logic [1:0] SEL_ROW = 2'd2;

   // Values loaded into the sprite control registers on reset.
   localparam logic RST_ENABLE = 1'b0;
   localparam logic RST_BOUNCE = 1'b0;

   // A pixel is stored as {enable, rgb}.
   function automatic int ergb_width(input int rgb_w);
      return rgb_w + 1;
   endfunction

   // Enable bit sits directly above the packed {y, x} fields.
   function automatic int pos_en_bit(input int x_w, input int y_w);
      return x_w + y_w;
   endfunction

   // Bounce bit sits directly above the packed {dy, dx} fields.
   function automatic int vel_bnc_bit(input int dx_w, input int dy_w);
      return dx_w + dy_w;
   endfunction

   // One axis of per-frame motion. Arithmetic is done at int width, which
   // covers every legal coordinate plus velocity without overflow. flip
   // reports that a bounce edge was hit and the velocity must be negated.
   function automatic int move_axis(input int pos, input int vel, input logic bounce,
                                    input int scr, input int spr, output logic flip);
      int n;
      n    = pos + vel;
      flip = 1'b0;
      if (bounce) begin
         if (n < 0) begin
            n    = 0;
            flip = 1'b1;
         end else if (n > scr - spr) begin
            n    = scr - spr;
            flip = 1'b1;
         end
      end else begin
         if (n < 0) begin
            n = n + scr;
         end else if (n >= scr) begin
            n = n - scr;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/game_sprite_unit.sv
// One sprite: control registers, bitmap, per-frame motion and stage-1 hit test.
// Latency: 1 cycle from pixel_x/pixel_y to o_opaque/o_rgb.
// Backpressure: none; a new pixel is accepted every cycle.
// Ports: i_clk/i_reset, beam position, i_frame_start, pre-decoded write strobe
// with select/row/data, registered opaque flag and colour for this sprite.
module game_sprite_unit
   import game_sprite_pkg::*;
#(
   parameter int SCREEN_WIDTH  = 640,
   parameter int SCREEN_HEIGHT = 480,
   parameter int SPRITE_WIDTH  = 8,
   parameter int SPRITE_HEIGHT = 8,
   parameter int X_WIDTH       = 10,
   parameter int Y_WIDTH       = 10,
   parameter int DX_WIDTH      = 4,
   parameter int DY_WIDTH      = 4,
   parameter int RGB_WIDTH     = 3,
   parameter int DATA_WIDTH    = 32,
   parameter int ROW_WIDTH     = 3
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_frame_start,
   input  logic [X_WIDTH-1:0]    i_pixel_x,
   input  logic [Y_WIDTH-1:0]    i_pixel_y,
   input  logic                  i_wr_en,
   input  logic [1:0]            i_wr_sel,
   input  logic [ROW_WIDTH-1:0]  i_wr_row,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   output logic                  o_opaque,
   output logic [RGB_WIDTH-1:0]  o_rgb
);

   localparam int EW     = ergb_width(RGB_WIDTH);
   localparam int CW     = $clog2(SPRITE_WIDTH);
   localparam int EN_BIT = pos_en_bit(X_WIDTH, Y_WIDTH);
   localparam int BN_BIT = vel_bnc_bit(DX_WIDTH, DY_WIDTH);

   logic                       r_en;
   logic                       r_bounce;
   logic [X_WIDTH-1:0]         r_x;
   logic [Y_WIDTH-1:0]         r_y;
   logic signed [DX_WIDTH-1:0] r_dx;
   logic signed [DY_WIDTH-1:0] r_dy;
   logic [DATA_WIDTH-1:0]      r_bmp [SPRITE_HEIGHT];

   logic w_wr_pos, w_wr_vel, w_wr_row, w_move;
   int   w_nx, w_ny;
   logic w_flip_x, w_flip_y;
   logic signed [DX_WIDTH-1:0] w_dx_neg;
   logic signed [DY_WIDTH-1:0] w_dy_neg;

   assign w_wr_pos = i_wr_en && (i_wr_sel == SEL_POS);
   assign w_wr_vel = i_wr_en && (i_wr_sel == SEL_VEL);
   assign w_wr_row = i_wr_en && (i_wr_sel == SEL_ROW);
   assign w_move   = i_frame_start && r_en;

   always_comb begin
      w_nx = move_axis(int'(r_x), int'(r_dx), r_bounce, SCREEN_WIDTH, SPRITE_WIDTH, w_flip_x);
      w_ny = move_axis(int'(r_y), int'(r_dy), r_bounce, SCREEN_HEIGHT, SPRITE_HEIGHT, w_flip_y);
   end

   // Negating the most-negative velocity would overflow; clamp to max positive.
   assign w_dx_neg = (r_dx == {1'b1, {(DX_WIDTH-1){1'b0}}}) ? {1'b0, {(DX_WIDTH-1){1'b1}}} : -r_dx;
   assign w_dy_neg = (r_dy == {1'b1, {(DY_WIDTH-1){1'b0}}}) ? {1'b0, {(DY_WIDTH-1){1'b1}}} : -r_dy;

   // A register write in the frame_start cycle overrides motion for that field.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_en     <= RST_ENABLE;
         r_bounce <= RST_BOUNCE;
         r_x      <= '0;
         r_y      <= '0;
         r_dx     <= '0;
         r_dy     <= '0;
      end else begin
         if (w_wr_pos) begin
            r_x  <= i_wr_data[X_WIDTH-1:0];
            r_y  <= i_wr_data[X_WIDTH +: Y_WIDTH];
            r_en <= i_wr_data[EN_BIT];
         end else if (w_move) begin
            r_x <= X_WIDTH'(w_nx);
            r_y <= Y_WIDTH'(w_ny);
         end
         if (w_wr_vel) begin
            r_dx     <= i_wr_data[DX_WIDTH-1:0];
            r_dy     <= i_wr_data[DX_WIDTH +: DY_WIDTH];
            r_bounce <= i_wr_data[BN_BIT];
         end else if (w_move) begin
            if (w_flip_x) r_dx <= w_dx_neg;
            if (w_flip_y) r_dy <= w_dy_neg;
         end
      end
   end

   // Bitmap contents survive reset; the enable bit hides stale data.
   always_ff @(posedge i_clk) begin
      if (w_wr_row) r_bmp[i_wr_row] <= i_wr_data;
   end

   // Stage 1 hit test. The extra MSB turns a negative difference into a large
   // unsigned value, so pixels left of/above the sprite never match.
   logic [X_WIDTH:0]      w_ddx;
   logic [Y_WIDTH:0]      w_ddy;
   logic                  w_in;
   logic [CW-1:0]         w_col_inv;
   logic [DATA_WIDTH-1:0] w_row_dat;
   logic [EW-1:0]         w_pix;

   always_comb begin
      w_ddx     = {1'b0, i_pixel_x} - {1'b0, r_x};
      w_ddy     = {1'b0, i_pixel_y} - {1'b0, r_y};
      w_in      = (w_ddx <= (X_WIDTH+1)'(SPRITE_WIDTH-1)) &&
                  (w_ddy <= (Y_WIDTH+1)'(SPRITE_HEIGHT-1));
      // Column 0 is the most significant pixel, i.e. slot SPRITE_WIDTH-1.
      w_col_inv = ~w_ddx[CW-1:0];
      w_row_dat = r_bmp[w_ddy[ROW_WIDTH-1:0]];
      w_pix     = w_row_dat[int'(w_col_inv) * EW +: EW];
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_opaque <= 1'b0;
         o_rgb    <= '0;
      end else begin
         o_opaque <= w_in && r_en && w_pix[EW-1];
         o_rgb    <= w_pix[RGB_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/game_sprite_engine.sv
// Multi-sprite engine: N sprites, fixed-priority pixel mux, frame collision mask.
// Latency: 2 cycles from pixel_x/pixel_y to rgb_en/rgb/hit_index.
// Backpressure: none; streams one pixel per cycle from the VGA timing.
// Ports: clk/reset, beam position and frame_start, register write port,
// winning colour/index, collision mask of the previous frame.
module game_sprite_engine
   import game_sprite_pkg::*;
#(
   parameter int N_SPRITES          = 4,
   parameter int SPRITE_INDEX_WIDTH = 2,
   parameter int SCREEN_WIDTH       = 640,
   parameter int SCREEN_HEIGHT      = 480,
   parameter int SPRITE_WIDTH       = 8,
   parameter int SPRITE_HEIGHT      = 8,
   parameter int X_WIDTH            = 10,
   parameter int Y_WIDTH            = 10,
   parameter int DX_WIDTH           = 4,
   parameter int DY_WIDTH           = 4,
   parameter int RGB_WIDTH          = 3,
   parameter int DATA_WIDTH         = SPRITE_WIDTH * ergb_width(RGB_WIDTH)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [X_WIDTH-1:0]               pixel_x,
   input  logic [Y_WIDTH-1:0]               pixel_y,
   input  logic                             frame_start,
   input  logic                             wr_en,
   input  logic [SPRITE_INDEX_WIDTH-1:0]    wr_sprite,
   input  logic [1:0]                       wr_sel,
   input  logic [$clog2(SPRITE_HEIGHT)-1:0] wr_row,
   input  logic [DATA_WIDTH-1:0]            wr_data,
   output logic                             rgb_en,
   output logic [RGB_WIDTH-1:0]             rgb,
   output logic [SPRITE_INDEX_WIDTH-1:0]    hit_index,
   output logic [N_SPRITES-1:0]             collision_mask
);

   logic [N_SPRITES-1:0] w_opq;
   logic [RGB_WIDTH-1:0] w_rgb_s1 [N_SPRITES];

   for (genvar gi = 0; gi < N_SPRITES; gi++) begin : g_spr
      game_sprite_unit #(
         .SCREEN_WIDTH  (SCREEN_WIDTH),
         .SCREEN_HEIGHT (SCREEN_HEIGHT),
         .SPRITE_WIDTH  (SPRITE_WIDTH),
         .SPRITE_HEIGHT (SPRITE_HEIGHT),
         .X_WIDTH       (X_WIDTH),
         .Y_WIDTH       (Y_WIDTH),
         .DX_WIDTH      (DX_WIDTH),
         .DY_WIDTH      (DY_WIDTH),
         .RGB_WIDTH     (RGB_WIDTH),
         .DATA_WIDTH    (DATA_WIDTH),
         .ROW_WIDTH     ($clog2(SPRITE_HEIGHT))
      ) u_unit (
         .i_clk         (clk),
         .i_reset       (reset),
         .i_frame_start (frame_start),
         .i_pixel_x     (pixel_x),
         .i_pixel_y     (pixel_y),
         .i_wr_en       (wr_en && (wr_sprite == SPRITE_INDEX_WIDTH'(gi))),
         .i_wr_sel      (wr_sel),
         .i_wr_row      (wr_row),
         .i_wr_data     (wr_data),
         .o_opaque      (w_opq[gi]),
         .o_rgb         (w_rgb_s1[gi])
      );
   end

   // Priority: scan high to low so the lowest opaque index is written last.
   logic                          w_any;
   logic [SPRITE_INDEX_WIDTH-1:0] w_idx;
   logic [RGB_WIDTH-1:0]          w_rgb;
   logic [N_SPRITES-1:0]          w_hits;

   always_comb begin
      w_any = 1'b0;
      w_idx = '0;
      w_rgb = '0;
      for (int i = N_SPRITES - 1; i >= 0; i--) begin
         if (w_opq[i]) begin
            w_any = 1'b1;
            w_idx = SPRITE_INDEX_WIDTH'(i);
            w_rgb = w_rgb_s1[i];
         end
      end
      // x & (x-1) is non-zero exactly when two or more bits are set.
      w_hits = (|(w_opq & (w_opq - N_SPRITES'(1)))) ? w_opq : '0;
   end

   logic                          r_rgb_en;
   logic [RGB_WIDTH-1:0]          r_rgb;
   logic [SPRITE_INDEX_WIDTH-1:0] r_hit;
   logic [N_SPRITES-1:0]          r_acc;
   logic [N_SPRITES-1:0]          r_cmask;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rgb_en <= 1'b0;
         r_rgb    <= '0;
         r_hit    <= '0;
         r_acc    <= '0;
         r_cmask  <= '0;
      end else begin
         r_rgb_en <= w_any;
         r_rgb    <= w_rgb;
         r_hit    <= w_idx;
         // The frame_start cycle's own collisions land in the published mask.
         if (frame_start) begin
            r_cmask <= r_acc | w_hits;
            r_acc   <= '0;
         end else begin
            r_acc <= r_acc | w_hits;
         end
      end
   end

   assign rgb_en         = r_rgb_en;
   assign rgb            = r_rgb;
   assign hit_index      = r_hit;
   assign collision_mask = r_cmask;

endmodule

// File: tb/tb_game_sprite_engine.sv
// Directed self-checking bench for game_sprite_engine.
// Latency: probes wait two clocks after presenting a pixel.
// Backpressure: none.
module tb_game_sprite_engine;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  pixel_x, pixel_y;
   logic        frame_start, wr_en;
   logic [1:0]  wr_sprite, wr_sel;
   logic [2:0]  wr_row;
   logic [31:0] wr_data;
   logic        rgb_en;
   logic [2:0]  rgb;
   logic [1:0]  hit_index;
   logic [3:0]  collision_mask;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   game_sprite_engine dut (
      .clk            (clk),
      .reset          (reset),
      .pixel_x        (pixel_x),
      .pixel_y        (pixel_y),
      .frame_start    (frame_start),
      .wr_en          (wr_en),
      .wr_sprite      (wr_sprite),
      .wr_sel         (wr_sel),
      .wr_row         (wr_row),
      .wr_data        (wr_data),
      .rgb_en         (rgb_en),
      .rgb            (rgb),
      .hit_index      (hit_index),
      .collision_mask (collision_mask)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int s, input int sel, input int row, input logic [31:0] d);
      wr_en     = 1'b1;
      wr_sprite = 2'(s);
      wr_sel    = 2'(sel);
      wr_row    = 3'(row);
      wr_data   = d;
      tick();
      wr_en     = 1'b0;
   endtask

   task automatic wpos(input int s, input int x, input int y, input int en);
      wr(s, 0, 0, 32'((en << 20) | (y << 10) | x));
   endtask

   task automatic wvel(input int s, input int dx, input int dy, input int b);
      wr(s, 1, 0, 32'((b << 8) | ((dy & 15) << 4) | (dx & 15)));
   endtask

   task automatic wbmp(input int s, input logic [31:0] d);
      for (int r = 0; r < 8; r++) wr(s, 2, r, d);
   endtask

   task automatic frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   // Present a pixel, wait out the 2-cycle pipeline, then compare.
   task automatic probe(input string tag, input int x, input int y,
                        input logic en, input int c, input int idx);
      pixel_x = 10'(x);
      pixel_y = 10'(y);
      tick();
      tick();
      check({tag, ".en"}, 32'(rgb_en), 32'(en));
      if (en) begin
         check({tag, ".rgb"}, 32'(rgb), 32'(c));
         check({tag, ".idx"}, 32'(hit_index), 32'(idx));
      end
   endtask

   initial begin
      reset = 1'b1; pixel_x = '0; pixel_y = '0; frame_start = 1'b0;
      wr_en = 1'b0; wr_sprite = '0; wr_sel = '0; wr_row = '0; wr_data = '0;
      tick();
      tick();
      reset = 1'b0;
      check("rst.rgb_en", 32'(rgb_en), 32'd0);
      check("rst.rgb",    32'(rgb),    32'd0);
      check("rst.idx",    32'(hit_index), 32'd0);
      check("rst.cmask",  32'(collision_mask), 32'd0);

      // Bitmaps: colours 100, 010, 001, 111 for sprites 0..3.
      wbmp(0, 32'hcccccccc);
      wbmp(1, 32'haaaaaaaa);
      wbmp(2, 32'h99999999);
      wbmp(3, 32'hffffffff);

      // Single sprite and its bounding-box edges.
      wpos(0, 100, 50, 1);
      probe("s0.origin", 100, 50, 1'b1, 4, 0);
      probe("s0.corner", 107, 57, 1'b1, 4, 0);
      probe("s0.right",  108, 50, 1'b0, 0, 0);
      probe("s0.left",    99, 50, 1'b0, 0, 0);
      probe("s0.below",  100, 58, 1'b0, 0, 0);

      // Overlap, priority, transparent leftmost pixel and collision mask.
      wpos(0, 200, 200, 1);
      wpos(1, 200, 200, 1);
      wr(0, 2, 3, 32'h0ccccccc);
      probe("ovl.prio",  201, 200, 1'b1, 4, 0);
      probe("ovl.transp", 200, 203, 1'b1, 2, 1);
      frame();
      check("ovl.cmask", 32'(collision_mask), 32'h3);
      frame();
      check("ovl.cmask_clr", 32'(collision_mask), 32'h0);
      wpos(0, 200, 200, 0);
      wpos(1, 200, 200, 0);

      // Wrap mode in both directions.
      wpos(3, 636, 300, 1);
      wvel(3, 6, 0, 0);
      frame();
      probe("wrap.pos.hit",  2, 300, 1'b1, 7, 3);
      probe("wrap.pos.miss", 1, 300, 1'b0, 0, 0);
      wpos(3, 1, 300, 1);
      wvel(3, -3, 0, 0);
      frame();
      probe("wrap.neg.hit",  638, 300, 1'b1, 7, 3);
      probe("wrap.neg.miss", 637, 300, 1'b0, 0, 0);

      // Bounce at the right edge, then travel back.
      wpos(3, 630, 300, 1);
      wvel(3, 5, 0, 1);
      frame();
      probe("bnc.edge.hit",  632, 300, 1'b1, 7, 3);
      probe("bnc.edge.miss", 631, 300, 1'b0, 0, 0);
      frame();
      probe("bnc.back.hit",  627, 300, 1'b1, 7, 3);
      probe("bnc.back.miss", 626, 300, 1'b0, 0, 0);

      // Bounce at the left edge with most-negative velocity: saturates to +7.
      wpos(3, 3, 300, 1);
      wvel(3, -8, 0, 1);
      frame();
      probe("sat.edge.hit", 0, 300, 1'b1, 7, 3);
      frame();
      probe("sat.step.miss", 6, 300, 1'b0, 0, 0);
      probe("sat.step.hit",  7, 300, 1'b1, 7, 3);
      wpos(3, 0, 300, 0);

      // Position write coinciding with frame_start wins over motion.
      wpos(2, 20, 100, 1);
      wvel(2, 4, 0, 0);
      frame_start = 1'b1;
      wpos(2, 10, 100, 1);
      frame_start = 1'b0;
      probe("wwin.hit",   10, 100, 1'b1, 1, 2);
      probe("wwin.left",   9, 100, 1'b0, 0, 0);
      probe("wwin.right", 18, 100, 1'b0, 0, 0);

      // Build a collision, then reset mid-line.
      wvel(2, 0, 0, 0);
      wpos(1, 10, 100, 1);
      probe("pre.rst", 10, 100, 1'b1, 2, 1);
      frame();
      check("pre.rst.cmask", 32'(collision_mask), 32'h6);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid.rst.cmask", 32'(collision_mask), 32'h0);
      check("mid.rst.en0",   32'(rgb_en), 32'd0);
      tick();
      check("mid.rst.en1",   32'(rgb_en), 32'd0);
      tick();
      check("mid.rst.en2",   32'(rgb_en), 32'd0);
      tick();
      check("mid.rst.dis",   32'(rgb_en), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
